// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, status bit positions and legality check for the alu wrapper
package alu_pkg;

   localparam int DATA_W = 16;

   localparam logic [4:0] INC = 5'b00001;
   localparam logic [4:0] DEC = 5'b00011;
   localparam logic [4:0] ADD = 5'b00100;
   localparam logic [4:0] ADC = 5'b00101;
   localparam logic [4:0] SUB = 5'b00110;
   localparam logic [4:0] SBB = 5'b00111;
   localparam logic [4:0] AND = 5'b01000;
   localparam logic [4:0] OR  = 5'b01001;
   localparam logic [4:0] XOR = 5'b01010;
   localparam logic [4:0] NOT = 5'b01011;
   localparam logic [4:0] SHL = 5'b10000;
   localparam logic [4:0] SHR = 5'b10001;
   localparam logic [4:0] SAL = 5'b10010;
   localparam logic [4:0] SAR = 5'b10011;
   localparam logic [4:0] ROL = 5'b10100;
   localparam logic [4:0] ROR = 5'b10101;
   localparam logic [4:0] RCL = 5'b10110;
   localparam logic [4:0] RCR = 5'b10111;

   localparam int CF_B = 5;
   localparam int ZF_B = 4;
   localparam int NF_B = 3;
   localparam int VF_B = 2;
   localparam int PF_B = 1;
   localparam int AF_B = 0;

   // ZF and PF set: what the alu reports for 0 op 0 with opcode 00000
   localparam logic [5:0] FLAGS_RST = 6'b010010;

   // Holes in the opcode map: 00010, 011xx and 11xxx. 00000 is a legal pass-through.
   function automatic logic op_is_legal(input logic [4:0] op);
      logic legal;
      legal = 1'b1;
      if (op == 5'b00010)
         legal = 1'b0;
      if (op[4:2] == 3'b011)
         legal = 1'b0;
      if (op[4:3] == 2'b11)
         legal = 1'b0;
      return legal;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode legality decode
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [4:0] op_i,
   output logic       legal_o
);

   assign legal_o = op_is_legal(op_i);

endmodule

// File: rtl/alu_flags_wb.sv
// rtl/alu_flags_wb.sv - registered handshake stage around the combinational alu with ACC and FLAGS state
module alu_flags_wb
   import alu_pkg::*;
#(
   parameter int         DATA_W    = 16,
   parameter int         CNT_W     = 16,
   parameter logic [5:0] FLAGS_RST = alu_pkg::FLAGS_RST
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_cin,
   input  logic              in_use_acc,
   input  logic              in_use_cf,
   input  logic              in_wr_acc,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [4:0]        alu_f,
   output logic              alu_cin,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [5:0]        alu_status,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [5:0]        out_status,
   output logic              out_err,
   output logic [DATA_W-1:0] acc,
   output logic [5:0]        flags,
   output logic [CNT_W-1:0]  op_count
);

   logic [DATA_W-1:0] acc_q;
   logic [5:0]        flags_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_result_q;
   logic [5:0]        out_status_q;
   logic              out_err_q;

   logic              legal;
   logic              accept;

   alu_op_decode u_decode (
      .op_i    (in_op),
      .legal_o (legal)
   );

   // Operand selection: ACC and FLAGS.CF are the registered values, so a
   // dependent op issued the cycle after its producer sees the update directly.
   always_comb begin
      alu_a   = in_use_acc ? acc_q : in_a;
      alu_b   = in_b;
      alu_f   = in_op;
      alu_cin = in_use_cf ? flags_q[CF_B] : in_cin;
   end

   // The output slot is free when empty or being drained this cycle; never ready in reset.
   assign in_ready = !rst && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Output slot, architectural state and op counter update on the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q        <= '0;
         flags_q      <= FLAGS_RST;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_status_q <= '0;
         out_err_q    <= 1'b0;
      end else if (accept) begin
         out_valid_q  <= 1'b1;
         out_result_q <= alu_result;
         out_status_q <= alu_status;
         out_err_q    <= !legal;
         if (legal) begin
            flags_q <= alu_status;
            cnt_q   <= cnt_q + 1'b1;
            if (in_wr_acc)
               acc_q <= alu_result;
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_status = out_status_q;
   assign out_err    = out_err_q;
   assign acc        = acc_q;
   assign flags      = flags_q;
   assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_flags_wb.sv
// tb/tb_alu_flags_wb.sv - directed self-checking bench for alu_flags_wb
module tb_alu_flags_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_cin;
   logic        in_use_acc;
   logic        in_use_cf;
   logic        in_wr_acc;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [4:0]  alu_f;
   logic        alu_cin;
   logic [15:0] alu_result;
   logic [5:0]  alu_status;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [5:0]  out_status;
   logic        out_err;
   logic [15:0] acc;
   logic [5:0]  flags;
   logic [15:0] op_count;

   int n_checks = 0;
   int n_errors = 0;

   alu_flags_wb dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_cin     (in_cin),
      .in_use_acc (in_use_acc),
      .in_use_cf  (in_use_cf),
      .in_wr_acc  (in_wr_acc),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_f      (alu_f),
      .alu_cin    (alu_cin),
      .alu_result (alu_result),
      .alu_status (alu_status),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_status (out_status),
      .out_err    (out_err),
      .acc        (acc),
      .flags      (flags),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   task automatic drive_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic use_acc, input logic use_cf, input logic wr_acc,
                           input logic [15:0] res, input logic [5:0] st);
      in_valid   = 1'b1;
      in_op      = op;
      in_a       = a;
      in_b       = b;
      in_cin     = cin;
      in_use_acc = use_acc;
      in_use_cf  = use_cf;
      in_wr_acc  = wr_acc;
      alu_result = res;
      alu_status = st;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive_op(5'b00000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 6'b010010);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (acc !== 16'h0000) begin n_errors++; $display("FAIL reset_acc: got %h expected 0000", acc); end
      n_checks++; if (flags !== 6'b010010) begin n_errors++; $display("FAIL reset_flags: got %b expected 010010", flags); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (op_count !== 16'd0) begin n_errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
   endtask

   task automatic test_add_adc;
      @(negedge clk);
      drive_op(5'b00100, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6'b110011);
      #1;
      n_checks++; if (alu_a !== 16'hFFFF) begin n_errors++; $display("FAIL add_alu_a: got %h expected FFFF", alu_a); end
      n_checks++; if (alu_f !== 5'b00100 || alu_b !== 16'h0001) begin n_errors++; $display("FAIL add_alu_fb: got %b/%h expected 00100/0001", alu_f, alu_b); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_result !== 16'h0000) begin n_errors++; $display("FAIL add_out_result: got %h expected 0000", out_result); end
      n_checks++; if (out_status !== 6'b110011) begin n_errors++; $display("FAIL add_out_status: got %b expected 110011", out_status); end
      n_checks++; if (acc !== 16'h0000) begin n_errors++; $display("FAIL add_acc: got %h expected 0000", acc); end
      n_checks++; if (flags !== 6'b110011) begin n_errors++; $display("FAIL add_flags: got %b expected 110011", flags); end
      @(negedge clk);
      drive_op(5'b00101, 16'hAAAA, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 6'b000000);
      #1;
      n_checks++; if (alu_cin !== 1'b1) begin n_errors++; $display("FAIL adc_alu_cin: got %b expected 1", alu_cin); end
      n_checks++; if (alu_a !== 16'h0000) begin n_errors++; $display("FAIL adc_alu_a: got %h expected 0000", alu_a); end
      @(posedge clk); #1;
      n_checks++; if (acc !== 16'h0001) begin n_errors++; $display("FAIL adc_acc: got %h expected 0001", acc); end
      n_checks++; if (op_count !== 16'd2) begin n_errors++; $display("FAIL adc_op_count: got %0d expected 2", op_count); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] exp_r [4];
      logic [5:0]  exp_s [4];
      logic [15:0] prev;
      exp_r = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
      exp_s = '{6'b001010, 6'b010011, 6'b000000, 6'b000000};
      @(negedge clk);
      drive_op(5'b00100, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 6'b001000);
      @(posedge clk); #1;
      n_checks++; if (acc !== 16'hFFFE) begin n_errors++; $display("FAIL chain_load_acc: got %h expected FFFE", acc); end
      prev = 16'hFFFE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_op(5'b00001, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, exp_r[i], exp_s[i]);
         #1;
         n_checks++; if (alu_a !== prev) begin n_errors++; $display("FAIL chain_alu_a[%0d]: got %h expected %h", i, alu_a, prev); end
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1 || out_result !== exp_r[i]) begin n_errors++; $display("FAIL chain_out[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_result, exp_r[i]); end
         prev = exp_r[i];
      end
      n_checks++; if (op_count !== 16'd7) begin n_errors++; $display("FAIL chain_op_count: got %0d expected 7", op_count); end
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      out_ready = 1'b0;
      drive_op(5'b00001, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 6'b000010);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
         n_checks++; if (out_result !== 16'h0002 || out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_hold[%0d]: got v=%b %h expected v=1 0002", i, out_valid, out_result); end
         n_checks++; if (acc !== 16'h0002) begin n_errors++; $display("FAIL bp_acc[%0d]: got %h expected 0002", i, acc); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_result !== 16'h0003 || acc !== 16'h0003) begin n_errors++; $display("FAIL bp_accept: got res=%h acc=%h expected 0003/0003", out_result, acc); end
      n_checks++; if (op_count !== 16'd8) begin n_errors++; $display("FAIL bp_op_count: got %0d expected 8", op_count); end
   endtask

   task automatic test_illegal_and_compare;
      @(negedge clk);
      drive_op(5'b11000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 6'b000000);
      @(posedge clk); #1;
      n_checks++; if (out_err !== 1'b1 || out_result !== 16'h1234) begin n_errors++; $display("FAIL illegal_out: got err=%b res=%h expected err=1 1234", out_err, out_result); end
      n_checks++; if (acc !== 16'h0003) begin n_errors++; $display("FAIL illegal_acc: got %h expected 0003", acc); end
      n_checks++; if (flags !== 6'b000010) begin n_errors++; $display("FAIL illegal_flags: got %b expected 000010", flags); end
      n_checks++; if (op_count !== 16'd8) begin n_errors++; $display("FAIL illegal_op_count: got %0d expected 8", op_count); end
      @(negedge clk);
      drive_op(5'b00110, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b010010);
      @(posedge clk); #1;
      n_checks++; if (out_err !== 1'b0) begin n_errors++; $display("FAIL cmp_out_err: got %b expected 0", out_err); end
      n_checks++; if (flags !== 6'b010010) begin n_errors++; $display("FAIL cmp_flags: got %b expected 010010", flags); end
      n_checks++; if (acc !== 16'h0003) begin n_errors++; $display("FAIL cmp_acc: got %h expected 0003", acc); end
      n_checks++; if (op_count !== 16'd9) begin n_errors++; $display("FAIL cmp_op_count: got %0d expected 9", op_count); end
   endtask

   task automatic test_drain_idle_x;
      @(negedge clk);
      in_valid = 1'b0;
      in_op = 'x; in_a = 'x; in_b = 'x; in_cin = 'x;
      in_use_acc = 'x; in_use_cf = 'x; in_wr_acc = 'x;
      alu_result = 'x; alu_status = 'x;
      out_ready = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
         n_checks++; if (out_result !== 16'h0000 || out_status !== 6'b010010) begin n_errors++; $display("FAIL drain_hold: got %h/%b expected 0000/010010", out_result, out_status); end
         n_checks++; if (acc !== 16'h0003 || flags !== 6'b010010 || op_count !== 16'd9) begin n_errors++; $display("FAIL idle_state: got acc=%h flags=%b cnt=%0d expected 0003/010010/9", acc, flags, op_count); end
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      out_ready = 1'b0;
      drive_op(5'b00100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 6'b000010);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || acc !== 16'h0100) begin n_errors++; $display("FAIL prerst_state: got v=%b acc=%h expected v=1 acc=0100", out_valid, acc); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (acc !== 16'h0000 || flags !== 6'b010010) begin n_errors++; $display("FAIL arst_acc_flags: got %h/%b expected 0000/010010", acc, flags); end
      n_checks++; if (op_count !== 16'd0 || out_result !== 16'h0000 || out_err !== 1'b0) begin n_errors++; $display("FAIL arst_regs: got cnt=%0d res=%h err=%b expected 0/0000/0", op_count, out_result, out_err); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL arst_in_ready: got %b expected 0", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_ready: got %b expected 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_add_adc();
      test_back_to_back();
      test_backpressure();
      test_illegal_and_compare();
      test_drain_idle_x();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_flags_wb.md
Name: alu_flags_wb

Overview:
Sequential wrapper stage that sits directly around the existing 16-bit combinational `alu`.
- Upstream side: accepts one operation per cycle via a valid/ready handshake.
- Execute: drives the `alu` operand, opcode and carry ports, then registers `Result` and `Status` one cycle later.
- State: holds a 16-bit accumulator (ACC) and the architectural FLAGS register {CF,ZF,NF,VF,PF,AF}. ACC can supply operand A; FLAGS.CF can supply Cin, so ADC/SBB/RCL/RCR chains work.
- Downstream side: a registered, backpressured output.

Parameters:
- DATA_W, 16, datapath width; fixed at 16 to match `alu`.
- CNT_W, 16, width of the executed-operation counter.
- FLAGS_RST, 6'b010010, FLAGS reset value (ZF=1, PF=1; matches `alu` output for 0,0,op 0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  stage can accept.
- in_op  in  5  `alu` opcode F.
- in_a  in  DATA_W  operand A; used when in_use_acc=0.
- in_b  in  DATA_W  operand B.
- in_cin  in  1  carry-in; used when in_use_cf=0.
- in_use_acc  in  1  1: A operand = ACC.
- in_use_cf  in  1  1: Cin = FLAGS.CF.
- in_wr_acc  in  1  1: write Result to ACC; 0: flags-only, compare-style.
- alu_a  out  DATA_W  to `alu` A.
- alu_b  out  DATA_W  to `alu` B.
- alu_f  out  5  to `alu` F.
- alu_cin  out  1  to `alu` Cin.
- alu_result  in  DATA_W  from `alu` Result.
- alu_status  in  6  from `alu` Status, bit5..0 = CF,ZF,NF,VF,PF,AF.
- out_valid  out  1  registered result available.
- out_ready  in  1  consumer accepts.
- out_result  out  DATA_W  registered Result.
- out_status  out  6  registered Status.
- out_err  out  1  result belongs to an illegal opcode.
- acc  out  DATA_W  current ACC.
- flags  out  6  current FLAGS.
- op_count  out  CNT_W  count of legal ops executed.

Behaviour:
- Reset (async assert, takes effect immediately):
  - acc=0, flags=FLAGS_RST, out_valid=0, out_result=0, out_status=0, out_err=0, op_count=0.
  - Any in-flight operation is discarded.
- Combinational `alu` drive, every cycle:
  - alu_a = in_use_acc ? acc : in_a.
  - alu_b = in_b, alu_f = in_op.
  - alu_cin = in_use_cf ? flags[5] : in_cin.
- Ready and accept:
  - in_ready = !out_valid || out_ready. It is 0 while rst is high.
  - accept = in_valid && in_ready.
- On the accept edge (latency 1):
  - out_result <= alu_result, out_status <= alu_status, out_valid <= 1.
  - Legal op: flags <= alu_status; acc <= alu_result if in_wr_acc; op_count <= op_count+1 (wraps at 2^CNT_W).
  - out_err <= !legal.
- Illegal opcodes: 00010, 01100–01111, 11000–11111.
  - Result/Status are still registered, with out_err=1.
  - acc, flags and op_count are unchanged.
  - Opcode 00000 is legal (pass-through, Result 0).
- No accept and out_ready=1: out_valid <= 0; out_result, out_status and out_err hold their last value.
- Simultaneous accept and out_ready: the new result replaces the old one, so full throughput is 1 op/cycle.
- Back-to-back dependency: ACC and FLAGS update on the accept edge, so the next cycle's operation sees the new values with no stall and no bypass needed.
- out_valid=1 with out_ready=0: in_ready=0; out_* and acc/flags/op_count hold; the in_valid request waits.
- X on in_* while in_valid=0 must not alter state.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (INC=00001, DEC=00011, ADD=00100, ADC=00101, SUB=00110, SBB=00111, AND=01000, OR=01001, XOR=01010, NOT=01011, SHL=10000, SHR=10001, SAL=10010, SAR=10011, ROL=10100, ROR=10101, RCL=10110, RCR=10111);
  - status bit indices CF_B=5, ZF_B=4, NF_B=3, VF_B=2, PF_B=1, AF_B=0;
  - FLAGS_RST;
  - function op_is_legal(op).
- One sub-module, alu_op_decode: combinational, in_op -> legal. `alu` itself is instantiated by the parent, not inside this block.

Test Plan:
1. Reset → acc=0000, flags=010010, out_valid=0, in_ready=1, op_count=0.
2. ADD in_a=FFFF, in_b=0001, use_acc=0, wr_acc=1 → next cycle out_result=0000, out_status=110011, acc=0000, flags=110011. Follow with ADC use_acc=1, in_b=0000, use_cf=1 → alu_cin=1, acc=0001.
3. Chain: acc=FFFE, four back-to-back INC with use_acc=1 → out_result FFFF,0000,0001,0002 on consecutive cycles; op_count +4.
4. Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_result stable, acc unchanged. Release out_ready → the pending op is accepted the next cycle.
5. Illegal op 11000 with in_a=1234, then SUB wr_acc=0 on 0005-0005 → first: out_err=1, acc, flags, op_count unchanged. Second: flags ZF=1, acc unchanged.
6. Assert rst asynchronously mid-stream, between edges, with out_valid=1 → out_valid=0, acc=0000, flags=010010 immediately, before the next clk edge.
